// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM command port among NREQ requesters.
// Optional watchdog abort is enabled by defining DRAM_ARB_WATCHDOG_EN.
module dram_arbiter #(
  parameter int          NREQ    = 2,
  parameter int          AW      = 24,
  parameter int          DW      = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_ena,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wr_data,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_done,
  output logic [DW-1:0]        rd_out,
  output logic [1:0]           grant_id,
  output logic                 err,
  output logic [AW-1:0]        m_addr,
  output logic                 m_write,
  output logic                 m_ena,
  output logic [DW-1:0]        m_wr_data,
  input  logic                 m_ack,
  input  logic                 m_busy,
  input  logic [DW-1:0]        m_rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        grant_id_q, grant_id_d;
  logic              guard_q, guard_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic              m_write_q, m_write_d;
  logic              m_ena_q, m_ena_d;
  logic [DW-1:0]     m_wr_data_q, m_wr_data_d;
  logic [NREQ-1:0]   req_ack_q, req_ack_d;
  logic [NREQ-1:0]   req_done_q, req_done_d;
  logic [DW-1:0]     rd_out_q, rd_out_d;
  logic              err_q, err_d;

  logic [3:0]        req_pad_s;
  logic [2:0]        idx_s;
  logic              found_s;
  logic [1:0]        win_s;
  logic [1:0]        ptr_next_s;
  logic [AW-1:0]     sel_addr_s;
  logic              sel_write_s;
  logic [DW-1:0]     sel_data_s;

`ifdef DRAM_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0]    wd_q, wd_d;
`endif

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] id);
    logic [NREQ-1:0] r;
    for (int i = 0; i < NREQ; i++) begin
      r[i] = (2'(i) == id);
    end
    return r;
  endfunction

  // Round-robin search from the pointer, wrapping modulo NREQ; also muxes the winner's fields.
  always_comb begin
    req_pad_s   = 4'(req_ena);
    idx_s       = 3'd0;
    found_s     = 1'b0;
    win_s       = 2'd0;
    sel_addr_s  = '0;
    sel_write_s = 1'b0;
    sel_data_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx_s = {1'b0, ptr_q} + 3'(i);
      if (idx_s >= 3'(NREQ)) begin
        idx_s = idx_s - 3'(NREQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_pad_s[idx_s[1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[1:0];
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (2'(i) == win_s) begin
        sel_addr_s  = req_addr[i*AW +: AW];
        sel_write_s = req_write[i];
        sel_data_s  = req_wr_data[i*DW +: DW];
      end else begin
        sel_write_s = sel_write_s;
      end
    end
    if (win_s == 2'(NREQ - 1)) begin
      ptr_next_s = 2'd0;
    end else begin
      ptr_next_s = win_s + 2'd1;
    end
  end

  // Next-state and registered-output logic of the handshake FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    guard_d     = guard_q;
    m_addr_d    = m_addr_q;
    m_write_d   = m_write_q;
    m_ena_d     = m_ena_q;
    m_wr_data_d = m_wr_data_q;
    req_ack_d   = '0;
    req_done_d  = '0;
    rd_out_d    = rd_out_q;
    err_d       = 1'b0;
`ifdef DRAM_ARB_WATCHDOG_EN
    wd_d        = wd_q;
`endif

    case (state_q)
      IDLE: begin
        // m_busy high also holds off grants while the DRAM initialises
        if (!m_busy && found_s) begin
          m_addr_d    = sel_addr_s;
          m_write_d   = sel_write_s;
          m_wr_data_d = sel_data_s;
          m_ena_d     = 1'b1;
          grant_id_d  = win_s;
          ptr_d       = ptr_next_s;
          state_d     = ISSUE;
`ifdef DRAM_ARB_WATCHDOG_EN
          wd_d        = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (m_ack) begin
          m_ena_d   = 1'b0;
          req_ack_d = onehot(grant_id_q);
          guard_d   = 1'b1;
          state_d   = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        // busy may rise a cycle after ack, so the first WAIT cycle never completes
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!m_busy) begin
          if (!m_write_q) begin
            rd_out_d = m_rd_data;
          end else begin
            rd_out_d = rd_out_q;
          end
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        req_done_d = onehot(grant_id_q);
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef DRAM_ARB_WATCHDOG_EN
    if ((state_q == ISSUE) || (state_q == WAIT)) begin
      if (wd_q == WDW'(TIMEOUT - 1)) begin
        m_ena_d    = 1'b0;
        req_ack_d  = '0;
        guard_d    = 1'b0;
        err_d      = 1'b1;
        req_done_d = onehot(grant_id_q);
        rd_out_d   = rd_out_q;
        state_d    = IDLE;
      end else begin
        wd_d = wd_q + WDW'(1);
      end
    end else begin
      wd_d = wd_d;
    end
`endif
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      grant_id_q  <= 2'd0;
      guard_q     <= 1'b0;
      m_addr_q    <= '0;
      m_write_q   <= 1'b0;
      m_ena_q     <= 1'b0;
      m_wr_data_q <= '0;
      req_ack_q   <= '0;
      req_done_q  <= '0;
      rd_out_q    <= '0;
      err_q       <= 1'b0;
`ifdef DRAM_ARB_WATCHDOG_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      guard_q     <= guard_d;
      m_addr_q    <= m_addr_d;
      m_write_q   <= m_write_d;
      m_ena_q     <= m_ena_d;
      m_wr_data_q <= m_wr_data_d;
      req_ack_q   <= req_ack_d;
      req_done_q  <= req_done_d;
      rd_out_q    <= rd_out_d;
      err_q       <= err_d;
`ifdef DRAM_ARB_WATCHDOG_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign req_ack   = req_ack_q;
  assign req_done  = req_done_q;
  assign rd_out    = rd_out_q;
  assign grant_id  = grant_id_q;
  assign err       = err_q;
  assign m_addr    = m_addr_q;
  assign m_write   = m_write_q;
  assign m_ena     = m_ena_q;
  assign m_wr_data = m_wr_data_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Table-driven bench for dram_arbiter plus directed multi-cycle sequences
// driven by a small DRAM model (ack 2 cycles after ena, busy 4 cycles).
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_ena = 2'b00;
  logic [1:0]  req_write = 2'b00;
  logic [47:0] req_addr = 48'h0;
  logic [15:0] req_wr_data = 16'h0;
  logic [1:0]  req_ack;
  logic [1:0]  req_done;
  logic [7:0]  rd_out;
  logic [1:0]  grant_id;
  logic        err;
  logic [23:0] m_addr;
  logic        m_write;
  logic        m_ena;
  logic [7:0]  m_wr_data;
  logic        m_ack;
  logic        m_busy;
  logic [7:0]  m_rd_data;

  logic        model_en = 1'b0;
  logic        tbl_ack = 1'b0;
  logic        tbl_busy = 1'b0;
  logic [7:0]  tbl_rd = 8'h00;
  logic        mdl_ack;
  logic        mdl_busy;
  logic [7:0]  mdl_rd;
  logic [1:0]  phase;
  logic [1:0]  dly;
  logic [7:0]  mem [16];

  int n_vec = 0;
  int n_err = 0;

  assign m_ack     = model_en ? mdl_ack  : tbl_ack;
  assign m_busy    = model_en ? mdl_busy : tbl_busy;
  assign m_rd_data = model_en ? mdl_rd   : tbl_rd;

  dram_arbiter #(.NREQ(2), .AW(24), .DW(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_ena(req_ena), .req_write(req_write), .req_addr(req_addr), .req_wr_data(req_wr_data),
    .req_ack(req_ack), .req_done(req_done), .rd_out(rd_out), .grant_id(grant_id), .err(err),
    .m_addr(m_addr), .m_write(m_write), .m_ena(m_ena), .m_wr_data(m_wr_data),
    .m_ack(m_ack), .m_busy(m_busy), .m_rd_data(m_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural DRAM: sees ena, acks two edges later, stays busy a few cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 2'd0; dly <= 2'd0; mdl_ack <= 1'b0; mdl_busy <= 1'b0; mdl_rd <= 8'h00;
    end else if (!model_en) begin
      phase <= 2'd0; dly <= 2'd0; mdl_ack <= 1'b0; mdl_busy <= 1'b0;
    end else begin
      case (phase)
        2'd0: if (m_ena) begin phase <= 2'd1; dly <= 2'd1; end
        2'd1: if (dly == 2'd0) begin
                mdl_ack <= 1'b1; mdl_busy <= 1'b1; phase <= 2'd2;
                if (m_write) mem[m_addr[3:0]] <= m_wr_data;
                else mdl_rd <= mem[m_addr[3:0]];
              end else dly <= dly - 2'd1;
        2'd2: begin mdl_ack <= 1'b0; dly <= 2'd2; phase <= 2'd3; end
        default: if (dly == 2'd0) begin mdl_busy <= 1'b0; phase <= 2'd0; end
                 else dly <= dly - 2'd1;
      endcase
    end
  end

  typedef struct {
    logic [1:0] ena;
    logic [1:0] wr;
    logic       ack;
    logic       busy;
    logic [7:0] rdd;
    logic       e_ena;
    logic       e_wr;
    logic [1:0] e_ack;
    logic [1:0] e_done;
    logic [7:0] e_rd;
    logic [1:0] e_gid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] ena, input logic [1:0] wr, input logic ack, input logic busy,
                     input logic [7:0] rdd, input logic e_ena, input logic e_wr, input logic [1:0] e_ack,
                     input logic [1:0] e_done, input logic [7:0] e_rd, input logic [1:0] e_gid);
    vec_t v;
    v = '{ena, wr, ack, busy, rdd, e_ena, e_wr, e_ack, e_done, e_rd, e_gid};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; model_en = 1'b0; tbl_ack = 1'b0; tbl_busy = 1'b0; tbl_rd = 8'h00;
    req_ena = 2'b00; req_write = 2'b00;
    #1;
    check("reset_outputs", 64'({m_ena, m_write, req_ack, req_done, rd_out, grant_id, err, m_addr, m_wr_data}), 64'h0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Hold requester r until ack, then drop and wait for done.
  task automatic run_op(input int r, output int acks, output int dones, output logic wd_at_ack,
                        output logic wr_at_ack);
    acks = 0; dones = 0; wd_at_ack = 1'b0; wr_at_ack = 1'b0;
    req_ena[r] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      if (req_ack[r]) begin
        acks++; req_ena[r] = 1'b0; wd_at_ack = (m_wr_data == 8'hC3); wr_at_ack = m_write;
      end
      if (req_done[r]) begin
        dones++;
        break;
      end
    end
    req_ena[r] = 1'b0;
  endtask

  initial begin
    int   acks, dones, bad, nd;
    logic wdok, wrok;
    logic [1:0] exp_id;

    // ena wr ack busy rdd | m_ena m_write req_ack req_done rd_out grant_id
    add(2'b01, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 2'd0);
    add(2'b01, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 2'd0);
    add(2'b01, 2'b00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 2'b01, 2'b00, 8'h00, 2'd0);
    add(2'b00, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 2'd0);
    add(2'b00, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 2'd0);
    add(2'b00, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 2'd0);
    add(2'b00, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 2'b00, 2'b00, 8'h5A, 2'd0);
    add(2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b01, 8'h5A, 2'd0);
    add(2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h5A, 2'd0);
    add(2'b10, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 2'b00, 8'h5A, 2'd1);
    add(2'b10, 2'b10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b10, 2'b00, 8'h5A, 2'd1);
    add(2'b00, 2'b00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 2'b00, 2'b00, 8'h5A, 2'd1);
    add(2'b00, 2'b00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 2'b00, 2'b00, 8'h5A, 2'd1);
    add(2'b00, 2'b00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 2'b00, 2'b10, 8'h5A, 2'd1);
    add(2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b00, 8'h5A, 2'd1);
    add(2'b11, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 2'b00, 8'h5A, 2'd0);
    add(2'b11, 2'b00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 2'b01, 2'b00, 8'h5A, 2'd0);
    add(2'b11, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h5A, 2'd0);
    add(2'b11, 2'b00, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 2'b00, 2'b00, 8'h77, 2'd0);
    add(2'b11, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b01, 8'h77, 2'd0);
    add(2'b11, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 2'b00, 8'h77, 2'd1);
    add(2'b10, 2'b00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 2'b10, 2'b00, 8'h77, 2'd1);
    add(2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h77, 2'd1);
    add(2'b00, 2'b00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 2'b00, 2'b00, 8'h11, 2'd1);
    add(2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 8'h11, 2'd1);
    add(2'b01, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h11, 2'd1);
    add(2'b01, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 2'b00, 8'h11, 2'd0);

    // Busy after reset blocks grants; first grant one cycle after busy falls.
    rst = 1'b1;
    req_addr[23:0] = 24'h000456;
    tbl_busy = 1'b1; req_ena = 2'b01;
    step();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (m_ena) bad++;
    end
    check("ena_while_busy", 64'(bad), 64'd0);
    tbl_busy = 1'b0;
    step();
    check("first_grant", 64'({m_ena, m_addr}), 64'({1'b1, 24'h000456}));

    // Cycle table: single read, write with guard, simultaneous requests, busy-held IDLE.
    reset_dut();
    req_addr = {24'hFFFFFF, 24'h000123};
    req_wr_data = {8'hC3, 8'h00};
    foreach (tbl[i]) begin
      req_ena = tbl[i].ena; req_write = tbl[i].wr; tbl_ack = tbl[i].ack;
      tbl_busy = tbl[i].busy; tbl_rd = tbl[i].rdd;
      step();
      check($sformatf("vec%0d", i), 64'({m_ena, m_write, req_ack, req_done, rd_out, grant_id}),
            64'({tbl[i].e_ena, tbl[i].e_wr, tbl[i].e_ack, tbl[i].e_done, tbl[i].e_rd, tbl[i].e_gid}));
    end

    // Write 0xC3 to 0xFFFFFF, then read it back.
    reset_dut();
    model_en = 1'b1;
    req_addr[23:0] = 24'hFFFFFF; req_wr_data[7:0] = 8'hC3; req_write = 2'b01;
    run_op(0, acks, dones, wdok, wrok);
    check("wr_pulses", 64'({acks[7:0], dones[7:0]}), 64'h0101);
    check("wr_data_out", 64'({wdok, wrok}), 64'b11);
    check("wr_rd_out_kept", 64'(rd_out), 64'h00);
    req_write = 2'b00;
    run_op(0, acks, dones, wdok, wrok);
    check("rd_pulses", 64'({acks[7:0], dones[7:0]}), 64'h0101);
    check("rd_back", 64'(rd_out), 64'hC3);

    // Round-robin: both requesters hold req_ena for six operations.
    reset_dut();
    model_en = 1'b1;
    req_write = 2'b00; req_ena = 2'b11;
    nd = 0;
    for (int c = 0; c < 400 && nd < 6; c++) begin
      step();
      if (req_done != 2'b00) begin
        exp_id = 2'(nd % 2);
        check($sformatf("rr_done%0d", nd), 64'({req_done, grant_id}), 64'({2'b01 << exp_id, exp_id}));
        nd++;
      end
    end
    req_ena = 2'b00;
    check("rr_count", 64'(nd), 64'd6);

    // Reset pulsed in WAIT; pending request is granted afresh after release.
    reset_dut();
    model_en = 1'b1;
    req_addr[47:24] = 24'h00ABCD; req_ena = 2'b10;
    bad = 1;
    for (int c = 0; c < 50; c++) begin
      step();
      if (req_ack[1]) begin bad = 0; break; end
    end
    check("pre_rst_ack", 64'(bad), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst", 64'({m_ena, req_ack, req_done, grant_id, err}), 64'h0);
    @(negedge clk) rst = 1'b0;
    bad = 1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (m_ena) begin bad = 0; break; end
    end
    check("regrant", 64'({bad[0], m_addr, grant_id}), 64'({1'b0, 24'h00ABCD, 2'd1}));
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (req_ack[1]) req_ena = 2'b00;
      if (req_done[1]) begin nd = 1; break; end
    end
    check("regrant_done", 64'(nd), 64'd1);

    // Watchdog: ack never arrives.
    reset_dut();
    req_addr[23:0] = 24'h000321; req_ena = 2'b01;
    step();
    check("wd_ena", 64'(m_ena), 64'd1);
`ifdef DRAM_ARB_WATCHDOG_EN
    bad = 0;
    for (int j = 1; j < 16; j++) begin
      step();
      if (!m_ena || err || (req_done != 2'b00)) bad++;
    end
    check("wd_hold", 64'(bad), 64'd0);
    req_ena = 2'b00;
    step();
    check("wd_abort", 64'({err, req_done, m_ena}), 64'({1'b1, 2'b01, 1'b0}));
`else
    bad = 0;
    for (int j = 0; j < 1000; j++) begin
      step();
      if (err) bad++;
    end
    check("no_wd_err", 64'(bad), 64'd0);
    check("no_wd_ena", 64'({m_ena, req_done}), 64'({1'b1, 2'b00}));
    req_ena = 2'b00;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Shares the single tms4464 DRAM command port (`m_addr`/`m_write`/`m_ena`/`m_ack`/`m_busy`/`rd_data`) between up to four requesters, for example the busy-beaver tape engine and a display or tape-dump scanner. It performs round-robin arbitration, latches the winning command and runs the DRAM ena/ack/busy handshake on the requester's behalf. It returns per-requester accept and completion pulses plus a shared read-data bus. It sits between the requester modules and `tms4464` inside the board top.

## Interface
- NREQ, 2: number of requesters (2..4).
- AW, 24: address width.
- DW, 8: data width.
- TIMEOUT, 1023: watchdog limit in cycles. Used only with `DRAM_ARB_WATCHDOG_EN`.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_ena  in  NREQ  per-requester request.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i uses `[i*AW +: AW]`.
- req_wr_data  in  NREQ*DW  packed write data.
- req_ack  out  NREQ  one-cycle pulse: command accepted by the DRAM.
- req_done  out  NREQ  one-cycle pulse: operation complete; `rd_out` valid.
- rd_out  out  DW  read data of the last completed read; held until the next completion.
- grant_id  out  2  index of the current or last granted requester.
- err  out  1  one-cycle pulse on watchdog abort.
- m_addr  out  AW  to DRAM.
- m_write  out  1  to DRAM.
- m_ena  out  1  to DRAM.
- m_wr_data  out  DW  to DRAM.
- m_ack  in  1  from DRAM.
- m_busy  in  1  from DRAM.
- m_rd_data  in  DW  from DRAM.

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE.
- Reset values: state IDLE; `m_ena`, `m_write`, `req_ack`, `req_done`, `err` = 0; `m_addr`, `m_wr_data`, `rd_out` = 0; `grant_id` = 0; round-robin pointer = 0.
- IDLE: grants only when `m_busy` = 0, which covers DRAM init after reset.
  - The search starts at pointer `p` and wraps modulo NREQ; the first asserted `req_ena` wins.
  - On a win: latch addr, write and data into `m_*`, set `grant_id`, set `p` to winner+1 (mod NREQ), go to ISSUE.
- ISSUE: `m_ena` = 1 and held until `m_ack` = 1.
  - On ack: `m_ena` is 0 from the next cycle, `req_ack[grant_id]` pulses the next cycle, go to WAIT.
- WAIT: the first WAIT cycle ignores `m_busy` (guard cycle).
  - After the guard cycle, on `m_busy` = 0: for reads capture `m_rd_data` into `rd_out`; writes leave `rd_out` unchanged. Go to DONE.
- DONE: `req_done[grant_id]` pulses for one cycle, then IDLE.
- Requester rules:
  - Hold `req_ena` and the command fields stable until `req_ack`.
  - Drop `req_ena` on or after `req_ack`, or keep it high to queue another operation.
  - Deasserting `req_ena` before the grant withdraws the request; fields are sampled only at grant.
- Simultaneous requests are resolved strictly by the pointer. With all requesters requesting continuously, grants rotate 0,1,…,NREQ-1,0.
- `req_ena` on a requester index ≥ NREQ does not exist; `grant_id` never exceeds NREQ-1.
- Reset mid-operation: every output returns to its reset value immediately (asynchronous). The DRAM controller must be reset in the same domain, and an aborted access has no defined effect on memory.

## Timing
- Request to `m_ena`: 1 cycle (`req_ena` sampled high in IDLE at edge k gives `m_ena` = 1 after edge k).
- `m_ack` at edge a: `m_ena` = 0 and `req_ack` = 1 after edge a; the guard cycle is a+1.
- First `m_busy` = 0 sampled at edge b ≥ a+2: `rd_out` updated after edge b; `req_done` = 1 after edge b+1 for one cycle.
- Back-to-back grants: the next `m_ena` rises 1 cycle after `req_done`, giving a minimum of 2 idle DRAM-port cycles between operations.
- `req_ack` and `req_done` are single-cycle and never overlap for the same requester.

## Configuration
- `DRAM_ARB_WATCHDOG_EN` defined:
  - A counter clears on entering ISSUE and increments each cycle in ISSUE and WAIT.
  - When it reaches TIMEOUT: drop `m_ena`, pulse `err` and `req_done[grant_id]` together, leave `rd_out` unchanged, return to IDLE. The pointer advances normally.
- Undefined: no counter, `err` tied to 0, and the arbiter waits indefinitely.

## Test plan
- Reset with `m_busy` = 1 for 50 cycles and `req_ena[0]` = 1: no `m_ena` until `m_busy` falls, then `m_ena` 1 cycle later with `m_addr` = `req_addr[0]`.
- Single read at addr 0x000123, DRAM model returning 0x5A, ack 2 cycles after ena, busy 4 cycles: `req_ack[0]` once, `req_done[0]` once, `rd_out` = 0x5A, `m_write` = 0.
- Requesters 0 and 1 both holding `req_ena` for 6 operations: grant sequence 0,1,0,1,0,1; `grant_id` matches every `req_done`.
- Write of 0xC3 at addr 0xFFFFFF, then read of the same address: `m_wr_data` = 0xC3 during the write, read returns 0xC3, `rd_out` unchanged by the write.
- `rst` pulsed while in WAIT: `m_ena`, `req_ack`, `req_done` = 0 and `grant_id` = 0 immediately; after release the pending request is granted afresh.
- With `DRAM_ARB_WATCHDOG_EN`, TIMEOUT = 16, `m_ack` never asserted: `err` and `req_done[0]` pulse 16 cycles after entering ISSUE and `m_ena` drops. Without the macro, `m_ena` is still high after 1000 cycles.
